// File: rtl/d_input_conditioner.sv
// Synchronises and debounces a raw async data input; emits a stable level plus update/edge strobes.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a held input change to d_out.
// Backpressure: none; en=0 freezes the filter while the synchroniser keeps running.
module d_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  input  logic en,
  output logic d_out,
  output logic d_valid,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   upd;

  assign s    = sync[SYNC_STAGES-1];
  assign busy = (state == COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din_raw};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt tracks how many consecutive samples have disagreed with d_out so far.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    upd       = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (s != d_out) begin
            if (DEBOUNCE_CYCLES == 1) begin
              upd     = 1'b1;
              cnt_nxt = '0;
            end else begin
              cnt_nxt   = CNT_ONE;
              state_nxt = COUNT;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        COUNT: begin
          if (s == d_out) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            upd       = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out   <= 1'b0;
      d_valid <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      d_valid <= upd;
      rise    <= upd & s;
      fall    <= upd & ~s;
      if (upd) begin
        d_out <= s;
      end
    end
  end

endmodule
